// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status bits, instruction codes, register names
// and the status priority normalisation used by the writeback stage.
package y86_pkg;

  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b1000;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;

  // Keep only the most severe condition: ADR > INS > HLT > AOK.
  function automatic logic [3:0] stat_norm(input logic [3:0] s);
    if (s[3])      return STAT_ADR;
    else if (s[2]) return STAT_INS;
    else if (s[1]) return STAT_HLT;
    else           return STAT_AOK;
  endfunction

endpackage

// File: rtl/writeback_regfile.sv
// 15-entry program register file: two combinational read ports, two write
// ports where the M port overrides the E port on the same index.
module regfile
  import y86_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] rval_a,
  output logic [DATA_W-1:0] rval_b
);

  logic [DATA_W-1:0] regs_q [15];
  logic [DATA_W-1:0] regs_d [15];

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 15; i++) begin
      if (we && dst_e != RNONE && dst_e == 4'(i)) regs_d[i] = val_e;
      // M checked after E so popq %rsp keeps the popped value.
      if (we && dst_m != RNONE && dst_m == 4'(i)) regs_d[i] = val_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rval_a = '0;
    rval_b = '0;
    for (int i = 0; i < 15; i++) begin
      if (src_a != RNONE && src_a == 4'(i)) rval_a = regs_q[i];
      if (src_b != RNONE && src_b == 4'(i)) rval_b = regs_q[i];
    end
  end

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, register file write-back,
// forwarding exports and the sticky processor status / halt.
module writeback #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic [3:0]        stat,
  output logic              halted
);

  import y86_pkg::*;

  logic [3:0]        w_stat_q,  w_stat_d;
  logic [3:0]        w_icode_q, w_icode_d;
  logic [DATA_W-1:0] w_vale_q,  w_vale_d;
  logic [DATA_W-1:0] w_valm_q,  w_valm_d;
  logic [3:0]        w_dste_q,  w_dste_d;
  logic [3:0]        w_dstm_q,  w_dstm_d;
  logic              halted_q,  halted_d;
  logic              w_fault;
  logic              w_hold;
  logic              rf_we;

  assign w_fault = (w_stat_q != STAT_AOK);
  // A terminating instruction stays in W so stat keeps its code once halted.
  assign w_hold  = halted_q || W_stall || w_fault;
  assign rf_we   = !halted_q && !w_fault;

  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_vale_d  = w_vale_q;
    w_valm_d  = w_valm_q;
    w_dste_d  = w_dste_q;
    w_dstm_d  = w_dstm_q;
    halted_d  = halted_q || w_fault;
    if (!w_hold) begin
      if (W_bubble) begin
        w_stat_d  = STAT_AOK;
        w_icode_d = I_NOP;
        w_vale_d  = '0;
        w_valm_d  = '0;
        w_dste_d  = RNONE;
        w_dstm_d  = RNONE;
      end else begin
        w_stat_d  = stat_norm(m_stat);
        w_icode_d = m_icode;
        w_vale_d  = m_valE;
        w_valm_d  = m_valM;
        w_dste_d  = m_dstE;
        w_dstm_d  = m_dstM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_stat_q  <= STAT_AOK;
      w_icode_q <= I_NOP;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
      halted_q  <= 1'b0;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
      halted_q  <= halted_d;
    end
  end

  regfile #(
    .DATA_W (DATA_W),
    .RNONE  (RNONE)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .dst_e  (w_dste_q),
    .val_e  (w_vale_q),
    .dst_m  (w_dstm_q),
    .val_m  (w_valm_q),
    .src_a  (d_srcA),
    .src_b  (d_srcB),
    .rval_a (d_rvalA),
    .rval_b (d_rvalB)
  );

  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_valE  = w_vale_q;
  assign W_valM  = w_valm_q;
  assign W_dstE  = w_dste_q;
  assign W_dstM  = w_dstm_q;
  // Bubbles are loaded with AOK, so W_stat is already the reported status.
  assign stat    = w_stat_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for the writeback stage: directed scenarios plus a
// randomized run compared against a behavioural model of the stage.
module tb_writeback;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    m_stat, m_icode, m_dstE, m_dstM, d_srcA, d_srcB;
  logic [DW-1:0] m_valE, m_valM, d_rvalA, d_rvalB, W_valE, W_valM;
  logic          W_stall, W_bubble, halted;
  logic [3:0]    W_stat, W_icode, W_dstE, W_dstM, stat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback #(.DATA_W(DW), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .stat(stat), .halted(halted)
  );

  // Reference model state
  logic [DW-1:0] mreg [15];
  logic [3:0]    mw_stat, mw_icode, mw_dstE, mw_dstM;
  logic [DW-1:0] mw_valE, mw_valM;
  logic          mh;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] norm(input logic [3:0] s);
    for (int b = 3; b >= 0; b--)
      if (s[b]) return 4'(1 << b);
    return 4'b0001;
  endfunction

  function automatic logic [DW-1:0] mread(input logic [3:0] src);
    if (src == 4'hF) return '0;
    return mreg[src];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mreg[i] = '0;
    mw_stat = 4'b0001; mw_icode = 4'h1; mw_valE = '0; mw_valM = '0;
    mw_dstE = 4'hF;    mw_dstM = 4'hF;  mh = 1'b0;
  endtask

  task automatic model_edge();
    logic term;
    term = mh || (mw_stat != 4'b0001);
    if (!term) begin
      if (mw_dstE != 4'hF) mreg[mw_dstE] = mw_valE;
      if (mw_dstM != 4'hF) mreg[mw_dstM] = mw_valM;
    end
    if (!term && !W_stall) begin
      if (W_bubble) begin
        mw_stat = 4'b0001; mw_icode = 4'h1; mw_valE = '0; mw_valM = '0;
        mw_dstE = 4'hF;    mw_dstM = 4'hF;
      end else begin
        mw_stat = norm(m_stat); mw_icode = m_icode; mw_valE = m_valE;
        mw_valM = m_valM;       mw_dstE = m_dstE;   mw_dstM = m_dstM;
      end
    end
    mh = term;
  endtask

  task automatic check_all();
    chk("W_stat",  W_stat,  mw_stat);
    chk("W_icode", W_icode, mw_icode);
    chk("W_valE",  W_valE,  mw_valE);
    chk("W_valM",  W_valM,  mw_valM);
    chk("W_dstE",  W_dstE,  mw_dstE);
    chk("W_dstM",  W_dstM,  mw_dstM);
    chk("stat",    stat,    mw_stat);
    chk("halted",  halted,  mh);
    chk("d_rvalA", d_rvalA, mread(d_srcA));
    chk("d_rvalB", d_rvalB, mread(d_srcB));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_m(input logic [3:0] s, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [DW-1:0] ve, input logic [DW-1:0] vm);
    m_stat = s; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
  endtask

  task automatic rand_m();
    set_m(4'b0001, 4'($urandom_range(1, 11)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
    d_srcA = 4'($urandom_range(0, 15));
    d_srcB = 4'($urandom_range(0, 15));
  endtask

  // Assert reset between clock edges and check it acts without an edge.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_W_icode", W_icode, 4'h1);
    chk("rst_W_dstE",  W_dstE,  4'hF);
    chk("rst_W_stat",  W_stat,  4'b0001);
    for (int i = 0; i < 15; i++) begin
      d_srcA = 4'(i);
      #1 chk("rst_reg", d_rvalA, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_stat",   stat,   4'b0001);
    chk("rst_halted", halted, 1'b0);
  endtask

  logic [DW-1:0] r3_val;

  initial begin
    W_stall = 1'b0; W_bubble = 1'b0; d_srcA = 4'h0; d_srcB = 4'h0;
    set_m(4'b0001, 4'h1, 4'hF, 4'hF, '0, '0);
    mid_reset();

    // irmovq $0x1234, %rdx
    set_m(4'b0001, 4'h3, 4'h2, 4'hF, 64'h1234, '0);
    d_srcA = 4'h2;
    step();
    chk("irm_W_valE", W_valE, 64'h1234);
    chk("irm_old_read", d_rvalA, 64'h0);
    set_m(4'b0001, 4'h1, 4'hF, 4'hF, '0, '0);
    step();
    chk("irm_new_read", d_rvalA, 64'h1234);

    // popq %rsp
    set_m(4'b0001, 4'hB, 4'h4, 4'h4, 64'h108, 64'hBEEF);
    d_srcB = 4'h4;
    step();
    set_m(4'b0001, 4'h1, 4'hF, 4'hF, '0, '0);
    step();
    chk("popq_rsp", d_rvalB, 64'hBEEF);

    // stall beats bubble, then bubble alone
    set_m(4'b0001, 4'h2, 4'h6, 4'hF, 64'hAAAA, '0);
    step();
    set_m(4'b0001, 4'h5, 4'h7, 4'h8, 64'h5555, 64'h6666);
    W_stall = 1'b1; W_bubble = 1'b1;
    step();
    chk("stall_valE",  W_valE,  64'hAAAA);
    chk("stall_icode", W_icode, 4'h2);
    W_stall = 1'b0;
    step();
    chk("bub_icode", W_icode, 4'h1);
    chk("bub_dstE",  W_dstE,  4'hF);
    chk("bub_dstM",  W_dstM,  4'hF);
    W_bubble = 1'b0;

    // Randomized traffic with occasional stall/bubble and one mid-run reset
    for (int n = 0; n < 300; n++) begin
      rand_m();
      W_stall  = ($urandom_range(0, 7) == 0);
      W_bubble = ($urandom_range(0, 7) == 0);
      step();
      if (n == 150) mid_reset();
    end
    W_stall = 1'b0; W_bubble = 1'b0;

    // ADR fault on a load into %rbx
    r3_val = {$urandom, $urandom};
    set_m(4'b0001, 4'h3, 4'h3, 4'hF, r3_val, '0);
    step();
    set_m(4'b1001, 4'h5, 4'hF, 4'h3, '0, 64'hDEAD);
    d_srcA = 4'h3;
    step();
    chk("adr_W_stat", W_stat, 4'b1000);
    chk("adr_halted_early", halted, 1'b0);
    chk("adr_reg3", d_rvalA, r3_val);
    set_m(4'b0001, 4'h3, 4'h5, 4'hF, 64'h77, '0);
    step();
    chk("adr_halted", halted, 1'b1);
    chk("adr_reg3_kept", d_rvalA, r3_val);
    for (int n = 0; n < 5; n++) begin
      rand_m();
      step();
    end
    chk("adr_stat_held", stat, 4'b1000);
    chk("adr_dstM_held", W_dstM, 4'h3);

    // halt instruction
    mid_reset();
    set_m(4'b0010, 4'h0, 4'hF, 4'hF, '0, '0);
    step();
    chk("hlt_stat", stat, 4'b0010);
    set_m(4'b0001, 4'h3, 4'h1, 4'hF, 64'h99, '0);
    step();
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_stat_held", stat, 4'b0010);
    mid_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
